// File: rtl/trig_pkg.sv
// Shared types and constants for the Taylor-series trig engine:
// controller states, function select and the coefficient generator.
package trig_pkg;

    localparam int MAX_TERMS = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SQR    = 3'd2,
        S_MUL_X2 = 3'd3,
        S_MUL_C  = 3'd4,
        S_CHK    = 3'd5,
        S_ACC    = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    typedef enum logic {
        MODE_COS = 1'b0,
        MODE_SIN = 1'b1
    } mode_t;

    // Ratio between consecutive series terms (excluding the x^2 factor), in units of 2^-w.
    function automatic logic [63:0] coef(input mode_t m, input int k, input int w);
        int den;
        if (k < 32'sd1) begin
            den = 32'sd0;
        end else if (m == MODE_SIN) begin
            den = (32'sd2 * k) * (32'sd2 * k + 32'sd1);
        end else begin
            den = (32'sd2 * k - 32'sd1) * (32'sd2 * k);
        end
        if (den == 32'sd0) begin
            return 64'd0;
        end else begin
            return (64'd1 << w) / 64'(den);
        end
    endfunction

endpackage

// File: rtl/trig_coef_rom.sv
// Combinational coefficient table for cos and sin, elaborated from trig_pkg::coef.
// Index 0 and indices at or beyond TERMS read as zero.
module trig_coef_rom
    import trig_pkg::*;
#(
    parameter int W     = 16,
    parameter int TERMS = 6
)(
    input  mode_t                        mode,
    input  logic [$clog2(TERMS+1)-1:0]   index,
    output logic [W-1:0]                 coef_val
);

    localparam int IW = $clog2(TERMS + 1);

    logic [W-1:0] cos_tab_s [2**IW];
    logic [W-1:0] sin_tab_s [2**IW];

    for (genvar i = 0; i < 2**IW; i++) begin : g_tab
        if (i > 0 && i < TERMS) begin : g_used
            assign cos_tab_s[i] = W'(coef(MODE_COS, i, W));
            assign sin_tab_s[i] = W'(coef(MODE_SIN, i, W));
        end else begin : g_zero
            assign cos_tab_s[i] = '0;
            assign sin_tab_s[i] = '0;
        end
    end

    // Table lookup by function and term index.
    always_comb begin
        coef_val = '0;
        if (mode == MODE_SIN) begin
            coef_val = sin_tab_s[index];
        end else begin
            coef_val = cos_tab_s[index];
        end
    end

endmodule

// File: rtl/taylor_trig_engine.sv
// Fixed-point Taylor-series cos/sin engine: one shared (W+1)xW multiplier,
// four cycles per term, early exit once a term truncates to zero.
module taylor_trig_engine
    import trig_pkg::*;
#(
    parameter int W     = 16,
    parameter int TERMS = 6
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mode,
    input  logic [W-1:0]                 x,
    output logic                         ready,
    output logic                         done,
    output logic [W+1:0]                 result,
    output logic [$clog2(TERMS+1)-1:0]   terms_used
);

    localparam int KW = $clog2(TERMS + 1);
    localparam int PW = 2 * W + 1;
    localparam logic [W:0] ONE_T = {1'b1, {W{1'b0}}};

    state_t                state_r;
    state_t                state_s;
    logic [W-1:0]          x_r;
    mode_t                 mode_r;
    logic [W:0]            t_r;
    logic [W-1:0]          x2_r;
    logic signed [W+1:0]   acc_r;
    logic [KW-1:0]         k_r;
    logic                  sign_r;
    logic signed [W+1:0]   result_r;
    logic [KW-1:0]         terms_r;
    logic                  ready_r;
    logic                  done_r;

    logic [W:0]            mul_a_s;
    logic [W-1:0]          mul_b_s;
    logic [W:0]            shifted_s;
    logic [W-1:0]          coef_s;
    logic [KW-1:0]         k_inc_s;
    logic                  last_s;
    logic signed [W+1:0]   t_ext_s;
    logic signed [W+1:0]   acc_step_s;

    assign k_inc_s    = k_r + KW'(32'd1);
    assign last_s     = (k_inc_s == KW'(TERMS - 1));
    assign t_ext_s    = {1'b0, t_r};
    assign acc_step_s = sign_r ? (acc_r - t_ext_s) : (acc_r + t_ext_s);
    assign shifted_s  = (W+1)'((PW'(mul_a_s) * PW'(mul_b_s)) >> W);

    assign ready      = ready_r;
    assign done       = done_r;
    assign result     = result_r;
    assign terms_used = terms_r;

    // The coefficient for the term being built is c[mode][k+1].
    trig_coef_rom #(
        .W     (W),
        .TERMS (TERMS)
    ) u_coef_rom (
        .mode     (mode_r),
        .index    (k_inc_s),
        .coef_val (coef_s)
    );

    // Operand select for the shared multiplier.
    always_comb begin
        mul_a_s = '0;
        mul_b_s = '0;
        case (state_r)
            S_SQR: begin
                mul_a_s = {1'b0, x_r};
                mul_b_s = x_r;
            end
            S_MUL_X2: begin
                mul_a_s = t_r;
                mul_b_s = x2_r;
            end
            S_MUL_C: begin
                mul_a_s = t_r;
                mul_b_s = coef_s;
            end
            default: begin
                mul_a_s = '0;
                mul_b_s = '0;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_INIT;
                else       state_s = S_IDLE;
            end
            S_INIT: begin
                if (start) state_s = S_INIT;
                else       state_s = S_SQR;
            end
            S_SQR:    state_s = S_MUL_X2;
            S_MUL_X2: state_s = S_MUL_C;
            S_MUL_C:  state_s = S_CHK;
            S_CHK: begin
                if (t_r == '0) state_s = S_DONE;
                else           state_s = S_ACC;
            end
            S_ACC: begin
                if (last_s) state_s = S_DONE;
                else        state_s = S_MUL_X2;
            end
            S_DONE:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Datapath registers and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r      <= '0;
            mode_r   <= MODE_COS;
            t_r      <= '0;
            x2_r     <= '0;
            acc_r    <= '0;
            k_r      <= '0;
            sign_r   <= 1'b0;
            result_r <= '0;
            terms_r  <= '0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            ready_r <= (state_s == S_IDLE);
            done_r  <= (state_s == S_DONE);
            case (state_r)
                S_IDLE, S_INIT: begin
                    if (start) begin
                        x_r    <= x;
                        mode_r <= mode_t'(mode);
                    end else if (state_r == S_INIT) begin
                        // t0 is 1.0 for cos and x for sin; first update subtracts.
                        t_r    <= (mode_r == MODE_SIN) ? {1'b0, x_r} : ONE_T;
                        acc_r  <= (mode_r == MODE_SIN) ? $signed({2'b00, x_r})
                                                       : $signed({1'b0, ONE_T});
                        k_r    <= '0;
                        sign_r <= 1'b1;
                    end else begin
                        x_r <= x_r;
                    end
                end
                S_SQR: begin
                    x2_r <= shifted_s[W-1:0];
                end
                S_MUL_X2, S_MUL_C: begin
                    t_r <= shifted_s;
                end
                S_CHK: begin
                    if (t_r == '0) begin
                        result_r <= acc_r;
                        terms_r  <= k_inc_s;
                    end else begin
                        result_r <= result_r;
                    end
                end
                S_ACC: begin
                    acc_r  <= acc_step_s;
                    sign_r <= ~sign_r;
                    k_r    <= k_inc_s;
                    if (last_s) begin
                        result_r <= acc_step_s;
                        terms_r  <= KW'(TERMS);
                    end else begin
                        result_r <= result_r;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_taylor_trig_engine.sv
// Self-checking bench for taylor_trig_engine (W=16, TERMS=4): directed cases
// plus randomized runs compared with a plain-arithmetic series model.
module tb_taylor_trig_engine;

    localparam int W     = 16;
    localparam int TERMS = 4;
    localparam int TW    = $clog2(TERMS + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           mode;
    logic [W-1:0]   x;
    logic           ready;
    logic           done;
    logic [W+1:0]   result;
    logic [TW-1:0]  terms_used;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    taylor_trig_engine #(
        .W     (W),
        .TERMS (TERMS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .x          (x),
        .ready      (ready),
        .done       (done),
        .result     (result),
        .terms_used (terms_used)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Series cos/sin with floor truncation after every product; also predicts the done edge.
    function automatic void model(input logic m, input int xv, input int hold,
                                  output longint res, output int n, output int edg);
        longint t, acc, x2, c, den;
        int stop;
        x2   = (longint'(xv) * longint'(xv)) >> W;
        t    = m ? longint'(xv) : (longint'(1) << W);
        acc  = t;
        n    = 1;
        stop = 0;
        for (int k = 1; k < TERMS && stop == 0; k++) begin
            den = m ? longint'(2 * k * (2 * k + 1)) : longint'((2 * k - 1) * 2 * k);
            c   = (longint'(1) << W) / den;
            t   = (t * x2) >> W;
            t   = (t * c) >> W;
            if (t == 0) begin
                stop = k;
            end else begin
                acc = (k % 2 == 1) ? acc - t : acc + t;
                n++;
            end
        end
        res = acc;
        edg = ((stop != 0) ? 2 + 4 * stop : 3 + 4 * (TERMS - 1)) + hold - 1;
    endfunction

    task automatic run(input string tag, input logic m, input logic [W-1:0] xv,
                       input logic [W-1:0] xlast, input int hold);
        longint er;
        int     en, ee, edges;
        logic   rdy_ok;
        model(m, int'(xlast), hold, er, en, ee);
        mode   = m;
        x      = xv;
        start  = 1'b1;
        rdy_ok = 1'b1;
        edges  = 0;
        for (int i = 0; i < hold; i++) begin
            if (i == hold - 1) x = xlast;
            @(posedge clk); #1;
            edges++;
            if (ready !== 1'b0) rdy_ok = 1'b0;
        end
        start = 1'b0;
        x     = W'($urandom);
        mode  = 1'($urandom);
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (ready !== 1'b0) rdy_ok = 1'b0;
        end
        chk({tag, " done_edge"}, edges, ee);
        chk({tag, " result"}, $signed(result), er);
        chk({tag, " terms_used"}, terms_used, en);
        chk({tag, " ready_low"}, rdy_ok, 1);
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " ready_back"}, ready, 1);
    endtask

    initial begin
        int   dones, done_edge;
        logic m_r;
        logic [W-1:0] x_rand;
        longint er;
        int en, ee;

        rst = 1'b1; start = 1'b0; mode = 1'b0; x = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", ready, 1);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset terms", terms_used, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run("cos_x0", 1'b0, 16'h0000, 16'h0000, 1);
        chk("cos_x0 value", $signed(result), 65536);
        run("sin_x0", 1'b1, 16'h0000, 16'h0000, 1);
        run("cos_half", 1'b0, 16'h8000, 16'h8000, 1);
        chk("cos_half value", $signed(result), 57513);
        run("sin_half", 1'b1, 16'h8000, 16'h8000, 1);
        chk("sin_half value", $signed(result), 31420);
        chk("sin_half terms", terms_used, 3);

        // Reset while the first iteration sits in MUL_C.
        mode = 1'b0; x = 16'h8000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst ready", ready, 1);
        chk("midrst done", done, 0);
        chk("midrst result", result, 0);
        chk("midrst terms", terms_used, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run("after_rst", 1'b0, 16'h8000, 16'h8000, 1);

        run("held_start", 1'b0, 16'h4000, 16'h8000, 3);
        chk("held_start value", $signed(result), 57513);

        // A start pulse in MUL_X2 must not launch a second run.
        model(1'b0, 32'h4000, 1, er, en, ee);
        mode = 1'b0; x = 16'h4000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b1; x = 16'h1234;
        dones = 0; done_edge = 0;
        for (int e = 4; e <= 40; e++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (done_edge == 0) done_edge = e;
            end
        end
        chk("pulse done_count", dones, 1);
        chk("pulse done_edge", done_edge, ee);
        chk("pulse result", $signed(result), er);

        run("cos_max", 1'b0, 16'hFFFF, 16'hFFFF, 1);
        run("sin_max", 1'b1, 16'hFFFF, 16'hFFFF, 1);
        for (int i = 0; i < 10; i++) begin
            m_r    = 1'($urandom);
            x_rand = W'($urandom);
            run("random", m_r, x_rand, x_rand, int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
